serial_word_deserializer: RTL

Downstream consumer of the conditional-invert bit stage. It collects the registered single-bit stream into WIDTH-bit words, framed by a start-of-frame marker. It presents each word on a valid/ready output port and flags overflow. It sits between the bit-level datapath and the word-level sink, such as a metrics capture FIFO.

---
 rtl/serial_word_deserializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_word_deserializer.sv
// Serial-to-word deserializer: SOF-framed bit stream into WIDTH-bit words on a valid/ready port.
// Optional even-parity check on a trailing bit is enabled by defining DESER_PARITY_CHECK_EN.
module serial_word_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BIT_IN,
  input  logic             BIT_VLD,
  input  logic             BIT_SOF,
  input  logic             OUT_RDY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VLD,
  output logic             OVF,
  output logic             BUSY,
  output logic             PAR_ERR
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
`ifdef DESER_PARITY_CHECK_EN
  localparam logic [1:0] PARITY  = 2'd2;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_p0, state_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic [WIDTH-1:0] sh_p0, sh_nxt;
  logic             commit;
  logic [WIDTH-1:0] commit_word;
  logic [WIDTH-1:0] out_data_p1;
  logic             vld_p1;
  logic             ovf_p1;
`ifdef DESER_PARITY_CHECK_EN
  logic             commit_perr;
  logic             par_err_p1;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return {w[WIDTH-2:0], b};
  endfunction

`ifdef DESER_PARITY_CHECK_EN
  function automatic logic even_par_err(input logic [WIDTH-1:0] w, input logic b);
    return (^w) ^ b;
  endfunction
`endif

  // Collector: an SOF bit restarts framing from any state, so resync needs no special case.
  always_comb begin
    state_nxt   = state_p0;
    cnt_nxt     = cnt_p0;
    sh_nxt      = sh_p0;
    commit      = 1'b0;
    commit_word = sh_p0;
`ifdef DESER_PARITY_CHECK_EN
    commit_perr = 1'b0;
`endif
    if (BIT_VLD) begin
      if (BIT_SOF) begin
        sh_nxt    = {{(WIDTH-1){1'b0}}, BIT_IN};
        cnt_nxt   = CNT_W'(1);
        state_nxt = COLLECT;
      end else begin
        case (state_p0)
          COLLECT: begin
            sh_nxt  = shift_in(sh_p0, BIT_IN);
            cnt_nxt = cnt_p0 + 1'b1;
            if (cnt_p0 == LAST_CNT) begin
`ifdef DESER_PARITY_CHECK_EN
              state_nxt   = PARITY;
`else
              commit      = 1'b1;
              commit_word = shift_in(sh_p0, BIT_IN);
              state_nxt   = IDLE;
              cnt_nxt     = '0;
`endif
            end
          end
`ifdef DESER_PARITY_CHECK_EN
          PARITY: begin
            commit      = 1'b1;
            commit_word = sh_p0;
            commit_perr = even_par_err(sh_p0, BIT_IN);
            state_nxt   = IDLE;
            cnt_nxt     = '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Stage p0 -> p1: collector state and output holding register with handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      sh_p0       <= '0;
      out_data_p1 <= '0;
      vld_p1      <= 1'b0;
      ovf_p1      <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
      par_err_p1  <= 1'b0;
`endif
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      sh_p0    <= sh_nxt;
      if (commit) begin
        if (!vld_p1 || OUT_RDY) begin
          out_data_p1 <= commit_word;
          vld_p1      <= 1'b1;
`ifdef DESER_PARITY_CHECK_EN
          par_err_p1  <= commit_perr;
`endif
        end else begin
          ovf_p1 <= 1'b1;
        end
      end else if (vld_p1 && OUT_RDY) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign OUT_DATA = out_data_p1;
  assign OUT_VLD  = vld_p1;
  assign OVF      = ovf_p1;
  assign BUSY     = (state_p0 != IDLE);
`ifdef DESER_PARITY_CHECK_EN
  assign PAR_ERR  = par_err_p1;
`else
  assign PAR_ERR  = 1'b0;
`endif

endmodule
